// File: rtl/renode_apb3_completer_bridge.sv
// APB3 completer that forwards decoded transfers to a valid/ready back-end.
// Optional back-end timeout: define APB3_COMPLETER_TIMEOUT_EN.
module renode_apb3_completer_bridge #(
  parameter int                      AddressWidth  = 20,
  parameter int                      DataWidth     = 32,
  parameter logic [AddressWidth-1:0] BaseAddress   = '0,
  parameter int unsigned             RegionSize    = 'h1000,
  parameter int unsigned             TimeoutCycles = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DataWidth-1:0]    pwdata,
  output logic                    pready,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pslverr,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [AddressWidth-1:0] req_addr,
  output logic [DataWidth-1:0]    req_wdata,
  input  logic                    rsp_valid,
  input  logic [DataWidth-1:0]    rsp_rdata,
  input  logic                    rsp_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int ALIGN_W = $clog2(DataWidth / 8);
  localparam logic [AddressWidth-1:0] ALIGN_MASK = AddressWidth'((1 << ALIGN_W) - 1);
  localparam logic [AddressWidth:0] REGION_END =
    {1'b0, BaseAddress} + (AddressWidth + 1)'(RegionSize);

  state_t                  state, state_nxt;
  logic                    drop_pending, drop_pending_d;
  logic                    setup_held, setup_held_d;
  logic                    pready_d, pslverr_d, req_valid_d, req_write_d;
  logic [DataWidth-1:0]    prdata_d, req_wdata_d;
  logic [AddressWidth-1:0] req_addr_d;
  logic                    start, decode_ok, accepted, rsp_hit, tmo_hit;

  // A setup seen while a stale response is outstanding is remembered so it can
  // be served from its access phase once the stale response has been discarded.
  assign start     = pselx && (!penable || setup_held);
  assign decode_ok = (paddr >= BaseAddress) && ({1'b0, paddr} < REGION_END) &&
                     ((paddr & ALIGN_MASK) == '0);
  assign accepted  = (state == WAIT) || ((state == REQ) && req_ready);
  assign rsp_hit   = accepted && rsp_valid;

`ifdef APB3_COMPLETER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TimeoutCycles - 1);
  logic [15:0] tmo_cnt;

  assign tmo_hit = ((state == REQ) || (state == WAIT)) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pready       <= 1'b0;
      prdata       <= '0;
      pslverr      <= 1'b0;
      req_valid    <= 1'b0;
      req_write    <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      drop_pending <= 1'b0;
      setup_held   <= 1'b0;
    end else begin
      state        <= state_nxt;
      pready       <= pready_d;
      prdata       <= prdata_d;
      pslverr      <= pslverr_d;
      req_valid    <= req_valid_d;
      req_write    <= req_write_d;
      req_addr     <= req_addr_d;
      req_wdata    <= req_wdata_d;
      drop_pending <= drop_pending_d;
      setup_held   <= setup_held_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !drop_pending) state_nxt = decode_ok ? REQ : DONE;
      REQ: begin
        if (!pselx)                      state_nxt = IDLE;
        else if (rsp_hit || tmo_hit)     state_nxt = DONE;
        else if (req_ready)              state_nxt = WAIT;
      end
      WAIT: begin
        if (!pselx)                      state_nxt = IDLE;
        else if (rsp_valid || tmo_hit)   state_nxt = DONE;
      end
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pready_d       = (state_nxt == DONE);
    req_valid_d    = (state_nxt == REQ);
    pslverr_d      = 1'b0;
    prdata_d       = '0;
    req_write_d    = req_write;
    req_addr_d     = req_addr;
    req_wdata_d    = req_wdata;
    drop_pending_d = drop_pending;
    setup_held_d   = setup_held;
    case (state)
      IDLE: begin
        if (drop_pending && rsp_valid) drop_pending_d = 1'b0;
        if (!pselx) begin
          setup_held_d = 1'b0;
        end else if (start && !drop_pending) begin
          setup_held_d = 1'b0;
          req_write_d  = pwrite;
          req_addr_d   = paddr - BaseAddress;
          req_wdata_d  = pwdata;
          pslverr_d    = !decode_ok;
        end else if (!penable) begin
          setup_held_d = 1'b1;
        end
      end
      REQ, WAIT: begin
        if (!pselx) begin
          drop_pending_d = accepted && !rsp_valid;
        end else if (rsp_hit) begin
          pslverr_d = rsp_error;
          prdata_d  = req_write ? '0 : rsp_rdata;
        end else if (tmo_hit) begin
          pslverr_d      = 1'b1;
          drop_pending_d = accepted;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_renode_apb3_completer_bridge.sv
// Directed bench for renode_apb3_completer_bridge (default region 0..0xFFF, 32-bit data).
// Timeout scenario runs only when APB3_COMPLETER_TIMEOUT_EN is defined.
module tb_renode_apb3_completer_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] paddr;
  logic        pselx, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        req_valid, req_ready, req_write;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] g_rd, g_wd;
  logic        g_err, g_req, g_wr;
  logic [19:0] g_addr;
  int          g_lat;

  always #5 clk = ~clk;

  renode_apb3_completer_bridge #(
    .AddressWidth(20), .DataWidth(32), .BaseAddress(20'h0),
    .RegionSize('h1000), .TimeoutCycles(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pselx = 0; penable = 0; req_ready = 0; rsp_valid = 0;
    end
  endtask

  // One APB transfer with a scripted back-end; returns at the cycle pready is seen.
  task automatic apb_xfer(input logic wr, input logic [19:0] a, input logic [31:0] wd,
                          input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rd, input logic er);
    int first_req, hs;
    @(posedge clk); #1;
    pselx = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
    req_ready = 0; rsp_valid = 0;
    first_req = -1; hs = -1; g_lat = -1; g_req = 0;
    g_rd = 'x; g_err = 'x; g_addr = '0; g_wr = 0; g_wd = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      penable = 1; req_ready = 0; rsp_valid = 0;
      if (pready) begin
        g_rd = prdata; g_err = pslverr; g_lat = k;
        break;
      end
      if (req_valid) begin
        if (first_req < 0) begin
          first_req = k; g_req = 1; g_addr = req_addr; g_wr = req_write; g_wd = req_wdata;
        end
        if (k - first_req >= rdy_dly) begin req_ready = 1; hs = k; end
      end
      if (hs >= 0 && k == hs + rsp_dly) begin
        rsp_valid = 1; rsp_rdata = rd; rsp_error = er;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0; pselx = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_error = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pready, pslverr, req_valid, req_write} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {pready, pslverr, req_valid, req_write});
    end
    checks++;
    if ({prdata, req_addr, req_wdata} !== '0) begin
      errors++; $display("FAIL reset_data prdata=%h req_addr=%h req_wdata=%h want 0", prdata, req_addr, req_wdata);
    end
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_write;
    apb_xfer(1'b1, 20'h10, 32'hDEADBEEF, 0, 1, 32'h5A5A5A5A, 1'b0);
    checks++;
    if (g_addr !== 20'h10 || g_wr !== 1'b1 || g_wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_req addr=%h wr=%b wd=%h want 10/1/deadbeef", g_addr, g_wr, g_wd);
    end
    checks++;
    if (g_lat !== 3) begin errors++; $display("FAIL write_latency got=%0d want=3", g_lat); end
    checks++;
    if (g_err !== 1'b0 || g_rd !== 32'h0) begin
      errors++; $display("FAIL write_resp pslverr=%b prdata=%h want 0/0", g_err, g_rd);
    end
    idle(1);
  endtask

  task automatic test_read_delay;
    apb_xfer(1'b0, 20'h20, 32'h0, 0, 5, 32'h1234, 1'b0);
    checks++;
    if (g_lat !== 7 || g_rd !== 32'h1234 || g_err !== 1'b0) begin
      errors++; $display("FAIL read_delay lat=%0d prdata=%h err=%b want 7/1234/0", g_lat, g_rd, g_err);
    end
    idle(1);
    checks++;
    if (pready !== 1'b0) begin errors++; $display("FAIL pready_one_cycle got=%b want=0", pready); end
  endtask

  task automatic test_decode_err;
    apb_xfer(1'b0, 20'h1000, 32'h0, 0, 1, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (g_req !== 1'b0 || g_lat !== 1 || g_err !== 1'b1 || g_rd !== 32'h0) begin
      errors++; $display("FAIL decode_oob req=%b lat=%0d err=%b prdata=%h want 0/1/1/0", g_req, g_lat, g_err, g_rd);
    end
    idle(1);
    apb_xfer(1'b0, 20'h3, 32'h0, 0, 1, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (g_req !== 1'b0 || g_lat !== 1 || g_err !== 1'b1 || g_rd !== 32'h0) begin
      errors++; $display("FAIL decode_misalign req=%b lat=%0d err=%b prdata=%h want 0/1/1/0", g_req, g_lat, g_err, g_rd);
    end
    idle(1);
    apb_xfer(1'b0, 20'hFFC, 32'h0, 0, 1, 32'h0000_0FFC, 1'b0);
    checks++;
    if (g_req !== 1'b1 || g_lat !== 3 || g_err !== 1'b0 || g_rd !== 32'h0FFC) begin
      errors++; $display("FAIL decode_last_word req=%b lat=%0d err=%b prdata=%h want 1/3/0/ffc", g_req, g_lat, g_err, g_rd);
    end
    idle(1);
  endtask

  task automatic test_rsp_error;
    apb_xfer(1'b1, 20'h14, 32'h1111, 0, 1, 32'h0, 1'b1);
    checks++;
    if (g_err !== 1'b1 || g_lat !== 3) begin
      errors++; $display("FAIL rsp_error err=%b lat=%0d want 1/3", g_err, g_lat);
    end
    idle(1);
    apb_xfer(1'b0, 20'h18, 32'h0, 0, 1, 32'h77, 1'b0);
    checks++;
    if (g_err !== 1'b0 || g_rd !== 32'h77) begin
      errors++; $display("FAIL after_error err=%b prdata=%h want 0/77", g_err, g_rd);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    apb_xfer(1'b0, 20'h100, 32'h0, 2, 1, 32'hA1A1A1A1, 1'b0);
    checks++;
    if (g_lat !== 5 || g_rd !== 32'hA1A1A1A1 || g_addr !== 20'h100) begin
      errors++; $display("FAIL b2b_first lat=%0d prdata=%h addr=%h want 5/a1a1a1a1/100", g_lat, g_rd, g_addr);
    end
    apb_xfer(1'b0, 20'h104, 32'h0, 0, 0, 32'hB2B2B2B2, 1'b0);
    checks++;
    if (g_lat !== 2 || g_rd !== 32'hB2B2B2B2 || g_addr !== 20'h104) begin
      errors++; $display("FAIL b2b_second lat=%0d prdata=%h addr=%h want 2/b2b2b2b2/104", g_lat, g_rd, g_addr);
    end
    idle(1);
  endtask

  task automatic test_abort;
    @(posedge clk); #1;
    pselx = 1; penable = 0; pwrite = 0; paddr = 20'h30;
    @(posedge clk); #1;
    penable = 1; req_ready = 1;
    checks++;
    if (req_valid !== 1'b1) begin errors++; $display("FAIL abort_req got=%b want=1", req_valid); end
    @(posedge clk); #1;
    req_ready = 0; pselx = 0; penable = 0;
    @(posedge clk); #1;
    pselx = 1; penable = 0; paddr = 20'h40;
    checks++;
    if (req_valid !== 1'b0 || pready !== 1'b0) begin
      errors++; $display("FAIL abort_idle req_valid=%b pready=%b want 0/0", req_valid, pready);
    end
    @(posedge clk); #1;
    penable = 1; rsp_valid = 1; rsp_rdata = 32'hAA; rsp_error = 0;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL abort_held req_valid=%b want=0", req_valid); end
    @(posedge clk); #1;
    rsp_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 20'h40) begin
      errors++; $display("FAIL abort_resume req_valid=%b addr=%h want 1/40", req_valid, req_addr);
    end
    req_ready = 1;
    @(posedge clk); #1;
    req_ready = 0; rsp_valid = 1; rsp_rdata = 32'h5555;
    @(posedge clk); #1;
    rsp_valid = 0;
    checks++;
    if (pready !== 1'b1 || prdata !== 32'h5555 || pslverr !== 1'b0) begin
      errors++; $display("FAIL abort_next pready=%b prdata=%h err=%b want 1/5555/0", pready, prdata, pslverr);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    pselx = 1; penable = 0; pwrite = 1; paddr = 20'h50; pwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    penable = 1; req_ready = 1;
    @(posedge clk); #1;
    req_ready = 0;
    checks++;
    if (req_addr !== 20'h50 || req_write !== 1'b1) begin
      errors++; $display("FAIL pre_reset addr=%h wr=%b want 50/1", req_addr, req_write);
    end
    rst_n = 0; pselx = 0; penable = 0;
    @(negedge clk);
    checks++;
    if ({pready, pslverr, req_valid, req_write} !== 4'b0 || {prdata, req_addr, req_wdata} !== '0) begin
      errors++; $display("FAIL mid_reset ctrl=%b addr=%h wdata=%h want all 0",
                         {pready, pslverr, req_valid, req_write}, req_addr, req_wdata);
    end
    @(posedge clk); #1; rst_n = 1;
    apb_xfer(1'b0, 20'h24, 32'h0, 0, 1, 32'h0BADCAFE, 1'b0);
    checks++;
    if (g_lat !== 3 || g_rd !== 32'h0BADCAFE || g_err !== 1'b0) begin
      errors++; $display("FAIL post_reset lat=%0d prdata=%h err=%b want 3/0badcafe/0", g_lat, g_rd, g_err);
    end
    idle(1);
  endtask

`ifdef APB3_COMPLETER_TIMEOUT_EN
  task automatic test_timeout;
    apb_xfer(1'b0, 20'h60, 32'h0, 0, 1000, 32'h0, 1'b0);
    checks++;
    if (g_lat !== 9 || g_err !== 1'b1 || g_rd !== 32'h0) begin
      errors++; $display("FAIL timeout lat=%0d err=%b prdata=%h want 9/1/0", g_lat, g_err, g_rd);
    end
    @(posedge clk); #1;
    pselx = 0; penable = 0; rsp_valid = 1; rsp_rdata = 32'hAA;
    idle(1);
    apb_xfer(1'b0, 20'h64, 32'h0, 0, 1, 32'h99, 1'b0);
    checks++;
    if (g_lat !== 3 || g_rd !== 32'h99 || g_err !== 1'b0) begin
      errors++; $display("FAIL after_timeout lat=%0d prdata=%h err=%b want 3/99/0", g_lat, g_rd, g_err);
    end
    idle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_delay();
    test_decode_err();
    test_rsp_error();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef APB3_COMPLETER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
